// File: rtl/reg_tx_pkg.sv
// Shared definitions for the register-datapath serial link.
// The receiver imports the same package, so line levels and the
// parity convention live here rather than in either end.
package reg_tx_pkg;

   // Frame sequencer states, 3-bit encoded
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   // Line level while nothing is being sent
   localparam logic IDLE_LEVEL  = 1'b1;

   // Line level of the start bit that opens every frame
   localparam logic START_LEVEL = 1'b0;

   // Line level of the stop bit that closes every frame
   localparam logic STOP_LEVEL  = 1'b1;

   // Even parity: the parity bit is the XOR of the data bits, so the
   // data plus parity always hold an even number of ones. The seed is
   // XORed in so an odd-parity link would only need this one constant.
   localparam logic PARITY_SEED = 1'b0;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider for the serial transmitter.
// Counts clocks 0..DIV-1 while enabled and flags the last clock of each
// bit period, so the frame sequencer knows when to advance.
module bit_tick_gen #(
   parameter int DIV = 4
) (
   input  logic Clock,
   input  logic Reset,
   input  logic rearm,
   input  logic enable,
   output logic tick
);

   // DIV=1 would give a zero-width counter, so keep at least one bit
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] div_cnt;

   // Divider counter: restarts on every new frame so the start bit gets a full period
   always_ff @(negedge Clock or negedge Reset) begin
      if (!Reset) begin
         div_cnt <= '0;
      end else if (rearm) begin
         div_cnt <= '0;
      end else if (enable) begin
         if (div_cnt == LAST_CNT) begin
            div_cnt <= '0;
         end else begin
            div_cnt <= div_cnt + CNT_W'(1);
         end
      end
   end

   assign tick = enable && (div_cnt == LAST_CNT);

endmodule

// File: rtl/reg_piso_tx.sv
// Parallel-in, serial-out frame transmitter.
// Accepts a word over a valid/ready handshake and sends it as
// start bit, data LSB first, optional even parity, stop bit,
// each bit held for DIV clocks. All state moves on the falling edge.
module reg_piso_tx
   import reg_tx_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int DIV       = 4,
   parameter int PARITY_EN = 1
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] Reg_In,
   input  logic             Load_Valid,
   output logic             Load_Ready,
   output logic             Ser_Out,
   output logic             Busy,
   output logic             Done
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   tx_state_t        state, state_n;
   logic [WIDTH-1:0] shreg, shreg_n;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
   logic             parity_q, parity_n;
   logic             ser_n, busy_n, ready_n, done_n;
   logic             accept;
   logic             tick;

   bit_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .Clock  (Clock),
      .Reset  (Reset),
      .rearm  (accept),
      .enable (Busy),
      .tick   (tick)
   );

   // Next-state logic: sequence the frame and precompute registered outputs
   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bit_cnt_n = bit_cnt;
      parity_n  = parity_q;
      accept    = 1'b0;
      done_n    = 1'b0;
      ser_n     = IDLE_LEVEL;
      busy_n    = 1'b0;
      ready_n   = 1'b1;

      case (state)
         IDLE: begin
            if (Load_Valid && Load_Ready) begin
               accept    = 1'b1;
               shreg_n   = Reg_In;
               parity_n  = PARITY_SEED ^ (^Reg_In);
               bit_cnt_n = '0;
               state_n   = START;
            end
         end
         START: begin
            if (tick) begin
               state_n = DATA;
            end
         end
         DATA: begin
            if (tick) begin
               shreg_n   = shreg >> 1;
               bit_cnt_n = bit_cnt + CNT_W'(1);
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt_n = '0;
                  state_n   = (PARITY_EN != 0) ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            if (tick) begin
               state_n = STOP;
            end
         end
         STOP: begin
            if (tick) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      case (state_n)
         IDLE:    ser_n = IDLE_LEVEL;
         START:   ser_n = START_LEVEL;
         DATA:    ser_n = shreg_n[0];
         PARITY:  ser_n = parity_n;
         STOP:    ser_n = STOP_LEVEL;
         default: ser_n = IDLE_LEVEL;
      endcase

      busy_n  = (state_n != IDLE);
      ready_n = (state_n == IDLE);
   end

   // State and output registers: reset forces an idle line at once, discarding any frame
   always_ff @(negedge Clock or negedge Reset) begin
      if (!Reset) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         parity_q   <= 1'b0;
         Ser_Out    <= IDLE_LEVEL;
         Busy       <= 1'b0;
         Load_Ready <= 1'b1;
         Done       <= 1'b0;
      end else begin
         state      <= state_n;
         shreg      <= shreg_n;
         bit_cnt    <= bit_cnt_n;
         parity_q   <= parity_n;
         Ser_Out    <= ser_n;
         Busy       <= busy_n;
         Load_Ready <= ready_n;
         Done       <= done_n;
      end
   end

endmodule

// File: tb/tb_reg_piso_tx.sv
// Bench for reg_piso_tx: two instances (parity/DIV=4 and no parity/DIV=1).
// Stimulus pushes hand-computed serial bit sequences into per-instance queues;
// a monitor on the rising edge pops them and checks the line bit by bit.
module tb_reg_piso_tx;

   typedef struct {
      logic [15:0] seq;
      int          len;
      bit          b2b;
   } frame_t;

   logic       Clock;
   logic       Reset;
   logic [3:0] rin  [2];
   logic       lv   [2];
   logic       rdy  [2];
   logic       ser  [2];
   logic       busy [2];
   logic       done [2];

   int errors = 0;
   int checks = 0;

   frame_t q0[$];
   frame_t q1[$];

   bit     active   [2];
   bit     justDone [2];
   int     pos      [2];
   frame_t cur      [2];

   reg_piso_tx #(.WIDTH(4), .DIV(4), .PARITY_EN(1)) dutA (
      .Clock      (Clock),
      .Reset      (Reset),
      .Reg_In     (rin[0]),
      .Load_Valid (lv[0]),
      .Load_Ready (rdy[0]),
      .Ser_Out    (ser[0]),
      .Busy       (busy[0]),
      .Done       (done[0])
   );

   reg_piso_tx #(.WIDTH(4), .DIV(1), .PARITY_EN(0)) dutB (
      .Clock      (Clock),
      .Reset      (Reset),
      .Reg_In     (rin[1]),
      .Load_Valid (lv[1]),
      .Load_Ready (rdy[1]),
      .Ser_Out    (ser[1]),
      .Busy       (busy[1]),
      .Done       (done[1])
   );

   // Free-running clock; DUT acts on falling edges, bench samples on rising edges
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Watchdog so a stuck DUT still ends the run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic actual, input logic expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
      end
   endtask

   // Wait for the instance to be ready, present one word, and queue its expected frame
   task automatic applyStimulus(input int d, input logic [3:0] data, input logic [15:0] seq,
                                input int len, input bit b2b, input bit keepValid);
      frame_t f;
      int     budget;
      budget = 0;
      while (rdy[d] !== 1'b1 && budget < 200) begin
         @(posedge Clock);
         budget++;
      end
      if (budget >= 200) begin
         checks++;
         errors++;
         $display("[TB] FAIL readyTimeout%0d: got %b expected 1", d, rdy[d]);
      end
      f.seq = seq;
      f.len = len;
      f.b2b = b2b;
      if (d == 0) q0.push_back(f);
      else        q1.push_back(f);
      rin[d] = data;
      lv[d]  = 1'b1;
      @(posedge Clock);
      if (!keepValid) begin
         lv[d]  = 1'b0;
         rin[d] = ~data;
      end
   endtask

   // Monitor: decode each instance's line against the queued expectations
   always @(posedge Clock) begin
      for (int i = 0; i < 2; i++) begin
         int  dv;
         int  idx;
         bit  frontB2b;
         dv = (i == 0) ? 4 : 1;
         if (Reset === 1'b0) begin
            active[i]   = 1'b0;
            justDone[i] = 1'b0;
            checkOutput($sformatf("rstSer%0d", i),   ser[i],  1'b1);
            checkOutput($sformatf("rstBusy%0d", i),  busy[i], 1'b0);
            checkOutput($sformatf("rstReady%0d", i), rdy[i],  1'b1);
            checkOutput($sformatf("rstDone%0d", i),  done[i], 1'b0);
         end else begin
            if (!active[i]) begin
               frontB2b = (i == 0) ? (q0.size() > 0 && q0[0].b2b) : (q1.size() > 0 && q1[0].b2b);
               if (justDone[i] && frontB2b) begin
                  checkOutput($sformatf("b2bStart%0d", i), busy[i], 1'b1);
               end
               justDone[i] = 1'b0;
               if (busy[i] === 1'b1) begin
                  if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                     checks++;
                     errors++;
                     $display("[TB] FAIL unexpectedFrame%0d: got frame start expected idle", i);
                  end else begin
                     cur[i]    = (i == 0) ? q0.pop_front() : q1.pop_front();
                     active[i] = 1'b1;
                     pos[i]    = 0;
                  end
               end else begin
                  checkOutput($sformatf("idleSer%0d", i),  ser[i],  1'b1);
                  checkOutput($sformatf("idleDone%0d", i), done[i], 1'b0);
               end
            end
            if (active[i]) begin
               if (pos[i] < cur[i].len * dv) begin
                  idx = pos[i] / dv;
                  checkOutput($sformatf("serBit%0d_%0d", i, idx), ser[i], cur[i].seq[cur[i].len - 1 - idx]);
                  checkOutput($sformatf("frameBusy%0d", i),  busy[i], 1'b1);
                  checkOutput($sformatf("frameReady%0d", i), rdy[i],  1'b0);
                  checkOutput($sformatf("earlyDone%0d", i),  done[i], 1'b0);
                  pos[i]++;
               end else begin
                  checkOutput($sformatf("donePulse%0d", i), done[i], 1'b1);
                  checkOutput($sformatf("doneReady%0d", i), rdy[i],  1'b1);
                  checkOutput($sformatf("doneBusy%0d", i),  busy[i], 1'b0);
                  checkOutput($sformatf("doneSer%0d", i),   ser[i],  1'b1);
                  active[i]   = 1'b0;
                  justDone[i] = 1'b1;
               end
            end
         end
      end
   end

   // Directed scenarios
   initial begin
      Reset  = 1'b1;
      lv[0]  = 1'b0;
      lv[1]  = 1'b0;
      rin[0] = 4'h0;
      rin[1] = 4'h0;
      for (int i = 0; i < 2; i++) begin
         active[i]   = 1'b0;
         justDone[i] = 1'b0;
         pos[i]      = 0;
      end

      // Asynchronous reset mid-cycle, checked before any clock edge
      #2 Reset = 1'b0;
      #1;
      checkOutput("asyncRstSer",   ser[0],  1'b1);
      checkOutput("asyncRstReady", rdy[0],  1'b1);
      checkOutput("asyncRstBusy",  busy[0], 1'b0);
      checkOutput("asyncRstDone",  done[0], 1'b0);
      repeat (2) @(posedge Clock);
      #2 Reset = 1'b1;
      @(posedge Clock);

      // No-parity, DIV=1: 0110 -> 0,0,1,1,0,1 ; 1001 -> 0,1,0,0,1,1
      applyStimulus(1, 4'b0110, 16'b001101, 6, 1'b0, 1'b0);
      applyStimulus(1, 4'b1001, 16'b010011, 6, 1'b0, 1'b0);
      repeat (10) @(posedge Clock);

      // Basic frame: 1011 -> 0,1,1,0,1,parity 1,stop 1
      applyStimulus(0, 4'b1011, 16'b0110111, 7, 1'b0, 1'b0);

      // Ignored load: frame 0110 -> 0,0,1,1,0,0,1 with a stray F request mid-frame
      applyStimulus(0, 4'h6, 16'b0011001, 7, 1'b0, 1'b0);
      repeat (5) @(posedge Clock);
      rin[0] = 4'hF;
      lv[0]  = 1'b1;
      @(posedge Clock);
      lv[0]  = 1'b0;
      repeat (40) @(posedge Clock);

      // Back-to-back with Load_Valid held: 3 -> 0,1,1,0,0,0,1 ; C -> 0,0,0,1,1,0,1
      applyStimulus(0, 4'h3, 16'b0110001, 7, 1'b0, 1'b1);
      applyStimulus(0, 4'hC, 16'b0001101, 7, 1'b1, 1'b0);
      repeat (5) @(posedge Clock);

      // Reset mid-frame during data bit 2 of word 5 (0,1,0,1,0,0,1)
      applyStimulus(0, 4'h5, 16'b0101001, 7, 1'b0, 1'b0);
      repeat (13) @(posedge Clock);
      #2 Reset = 1'b0;
      #1;
      checkOutput("midRstSer",   ser[0],  1'b1);
      checkOutput("midRstBusy",  busy[0], 1'b0);
      checkOutput("midRstReady", rdy[0],  1'b1);
      checkOutput("midRstDone",  done[0], 1'b0);
      repeat (2) @(posedge Clock);
      #2 Reset = 1'b1;
      @(posedge Clock);

      // Fresh frame after reset: A -> 0,0,1,0,1,0,1
      applyStimulus(0, 4'hA, 16'b0010101, 7, 1'b0, 1'b0);
      repeat (40) @(posedge Clock);

      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("[TB] FAIL pendingFrames: got %0d/%0d expected 0/0", q0.size(), q1.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
